rom_loader: RTL and testbench
=============================

Name: rom_loader

Overview:
Writer side of the instruction ROM. It takes a little-endian byte stream, for example from the APF bridge or a UART, packs it into 32-bit words and writes them to the ROM write port, starting at word 0. The ROM read side addresses words with byte address bits [11:2], so this block emits word-aligned byte addresses. It also holds the CPU in reset until a complete image has been written.

Parameters:
DEPTH_WORDS, 1024, ROM capacity in 32-bit words (4 KB)
LEN_W, 11, width of length_words; must satisfy 2**LEN_W > DEPTH_WORDS

Ports:
clk  input  1  system clock; all logic is on the rising edge
rst_n  input  1  asynchronous reset, active-low
start  input  1  one-cycle pulse that begins a load; ignored while busy=1
length_words  input  LEN_W  number of words to load; sampled on the accepted start
in_valid  input  1  a stream byte is present
in_data  input  8  stream byte
in_ready  output  1  loader accepts the byte this cycle
mem_we  output  1  ROM write strobe, one cycle per word
mem_addr  output  32  word-aligned byte address, {word_idx, 2'b00}
mem_wdata  output  32  packed word
busy  output  1  a load is in progress
done  output  1  last load completed without error; held until the next accepted start
error  output  1  last start had a length greater than DEPTH_WORDS; held until the next accepted start
cpu_rst_n  output  1  CPU reset, active-low; low until a successful load completes

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE.
  - in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - busy=0, done=0, error=0, cpu_rst_n=0.
  - Byte and word counters cleared.
  - Reset asserted mid-load aborts immediately. No further mem_we; partial ROM contents are left as they are.
- All outputs are registered. in_ready is the exception: it is combinational and equals (state==FILL).
- States: IDLE, FILL, WRITE, FINISH.
- IDLE, on start=1:
  - Latch length_words; clear done, error, word_idx and byte_cnt.
  - Drive cpu_rst_n=0 and busy=1.
  - length_words == 0: go to FINISH with done to be set and no writes.
  - length_words > DEPTH_WORDS: go to FINISH with error to be set and no writes.
  - Otherwise: go to FILL.
- FILL:
  - A byte is accepted when in_valid && in_ready.
  - Byte k (k = 0..3) is written to mem_wdata[8k+7:8k], so the first byte is the LSB.
  - byte_cnt increments on each accept.
  - On the 4th accept: byte_cnt wraps to 0 and the next state is WRITE.
  - in_valid=0 stalls FILL indefinitely; there is no timeout.
- WRITE (exactly one cycle):
  - mem_we=1, mem_addr = word_idx*4, mem_wdata holds the packed word; in_ready=0.
  - Next cycle: mem_we=0 and word_idx increments.
  - If word_idx+1 == length: go to FINISH. Otherwise go back to FILL.
- FINISH (one cycle):
  - busy=0.
  - On success: done=1 and cpu_rst_n=1.
  - On error: error=1 and cpu_rst_n stays 0.
  - Return to IDLE.
- Timing and throughput:
  - The word write (mem_we) occurs in the cycle after the 4th byte accept.
  - Peak rate is 4 bytes per 5 cycles.
  - busy drops, and done/cpu_rst_n rise, 2 cycles after the last mem_we cycle (WRITE, then FINISH, then visible).
- start while busy=1 is ignored; there is no restart.
- start in IDLE after a completed load begins a new load and drives cpu_rst_n=0 again.
- Bytes offered outside FILL are not accepted (in_ready=0). They are not lost; the stream simply waits.
- mem_addr never exceeds (DEPTH_WORDS-1)*4, and mem_addr[1:0] is always 0.

Test Plan:
- Basic load:
  - Stimulus: reset, start with length_words=2, bytes 78 56 34 12 EF BE AD DE with in_valid held high.
  - Required: writes (addr 0x0, data 0x12345678) then (addr 0x4, data 0xDEADBEEF); exactly 2 mem_we pulses; then done=1, cpu_rst_n=1, busy=0.
- Stalled stream:
  - Stimulus: same as basic load, but in_valid toggles 1/0 every cycle.
  - Required: identical write data and addresses; mem_we never asserts before the 4th accepted byte of each word.
- Boundary lengths:
  - length 0: done=1 within 2 cycles, no mem_we.
  - length 1025: error=1, done=0, cpu_rst_n=0, no mem_we.
  - length 1024 with 4096 bytes: last write is at addr 0xFFC, then done=1.
- Start while busy:
  - Stimulus: pulse start again mid-load with length 5.
  - Required: ignored; the original length is completed, with the correct word count and addresses.
- Reset mid-load:
  - Stimulus: assert rst_n=0 after 6 bytes of a 3-word load.
  - Required: all outputs go to their reset values asynchronously, with no further mem_we. A subsequent 1-word load writes addr 0 correctly.
- Reload:
  - Stimulus: after a successful load, start a second load with length 1.
  - Required: cpu_rst_n goes low the cycle after start and returns high after the single write completes.

Source files
------------

// File: rtl/rom_loader_if.sv
// rom_loader_if: byte-stream input and ROM write port of the ROM loader.
//   in_valid / in_data   : stream byte offered to the loader
//   in_ready             : loader accepts the offered byte this cycle
//   mem_we               : ROM write strobe, one cycle per word
//   mem_addr / mem_wdata : word-aligned byte address and packed word
// modport master: the loader side. modport slave: the stream source / ROM side.
interface rom_loader_if;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;

    modport master (
        input  in_valid,
        input  in_data,
        output in_ready,
        output mem_we,
        output mem_addr,
        output mem_wdata
    );

    modport slave (
        output in_valid,
        output in_data,
        input  in_ready,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata
    );
endinterface

// File: rtl/rom_loader.sv
// rom_loader: writer side of the instruction ROM. It packs a little-endian byte
// stream into 32-bit words and writes them from word 0 upwards, and it holds the
// CPU in reset until a complete image has been written.
//   clk, rst_n     : clock, asynchronous active-low reset
//   start          : one-cycle pulse that begins a load (ignored while busy)
//   length_words   : number of words to load, sampled on the accepted start
//   busy           : a load is in progress
//   done           : last load completed; held until the next accepted start
//   error          : last start had length > DEPTH_WORDS; held until next start
//   cpu_rst_n      : CPU reset, low until a successful load completes
//   bus            : byte stream in and ROM write port out (rom_loader_if.master)
module rom_loader #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LEN_W       = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] length_words,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic             cpu_rst_n,
    rom_loader_if.master     bus
);

    localparam int unsigned IDX_W  = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned BCNT_W = 2;
    localparam logic [LEN_W-1:0] DEPTH_LEN = LEN_W'(DEPTH_WORDS);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        WRITE  = 2'd2,
        FINISH = 2'd3
    } state_t;

    state_t              state_q,     state_d;
    logic [LEN_W-1:0]    len_q,       len_d;
    logic [IDX_W-1:0]    word_idx_q,  word_idx_d;
    logic [BCNT_W-1:0]   byte_cnt_q,  byte_cnt_d;
    logic                fail_q,      fail_d;
    logic                mem_we_q,    mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q,  mem_addr_d;
    logic [WORD_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                busy_q,      busy_d;
    logic                done_q,      done_d;
    logic                error_q,     error_d;
    logic                cpu_rst_n_q, cpu_rst_n_d;

    // Byte handshake; the only combinational output.
    logic in_ready_c;
    logic accept_c;
    logic last_word_c;

    assign in_ready_c  = (state_q == FILL);
    assign accept_c    = in_ready_c && bus.in_valid;
    assign last_word_c = ((LEN_W'(word_idx_q) + LEN_W'(1)) == len_q);

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            len_q       <= '0;
            word_idx_q  <= '0;
            byte_cnt_q  <= '0;
            fail_q      <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            cpu_rst_n_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            word_idx_q  <= word_idx_d;
            byte_cnt_q  <= byte_cnt_d;
            fail_q      <= fail_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
            cpu_rst_n_q <= cpu_rst_n_d;
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        word_idx_d  = word_idx_q;
        byte_cnt_d  = byte_cnt_q;
        fail_d      = fail_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        busy_d      = busy_q;
        done_d      = done_q;
        error_d     = error_q;
        cpu_rst_n_d = cpu_rst_n_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    len_d       = length_words;
                    word_idx_d  = '0;
                    byte_cnt_d  = '0;
                    done_d      = 1'b0;
                    error_d     = 1'b0;
                    busy_d      = 1'b1;
                    cpu_rst_n_d = 1'b0;
                    fail_d      = 1'b0;
                    if (length_words == '0) begin
                        state_d = FINISH;
                    end else if (length_words > DEPTH_LEN) begin
                        fail_d  = 1'b1;
                        state_d = FINISH;
                    end else begin
                        state_d = FILL;
                    end
                end
            end

            FILL: begin
                if (accept_c) begin
                    // Little-endian packing: byte k lands in bits [8k+7:8k].
                    mem_wdata_d[{byte_cnt_q, 3'b000} +: 8] = bus.in_data;
                    byte_cnt_d = byte_cnt_q + BCNT_W'(1);
                    if (byte_cnt_q == BCNT_W'(3)) begin
                        mem_we_d   = 1'b1;
                        mem_addr_d = ADDR_W'({word_idx_q, 2'b00});
                        state_d    = WRITE;
                    end
                end
            end

            WRITE: begin
                word_idx_d = word_idx_q + IDX_W'(1);
                state_d    = last_word_c ? FINISH : FILL;
            end

            FINISH: begin
                busy_d = 1'b0;
                if (fail_q) begin
                    error_d = 1'b1;
                end else begin
                    done_d      = 1'b1;
                    cpu_rst_n_d = 1'b1;
                end
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign error         = error_q;
    assign cpu_rst_n     = cpu_rst_n_q;

endmodule

// File: tb/tb_rom_loader.sv
// tb_rom_loader: directed stimulus for rom_loader; expected ROM writes are queued
// when a load is issued and a negedge monitor pops and compares each mem_we.
`timescale 1ns/1ps
module tb_rom_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [10:0] length_words;
    logic        busy, done, error, cpu_rst_n;

    rom_loader_if bus ();

    rom_loader #(.DEPTH_WORDS(1024), .LEN_W(11)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .length_words (length_words),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .cpu_rst_n    (cpu_rst_n),
        .bus          (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_q[$];
    wr_t         exp_e;
    logic [7:0]  bq[$];
    logic [31:0] wq[$];
    int          vectors = 0;
    int          miscompares = 0;
    int          we_cnt = 0;
    int          pend_bytes = 0;
    int          cyc = 0;
    int          last_we_cyc = 0;
    logic [31:0] last_addr = '0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endfunction

    // Scoreboard monitor: every write must follow exactly 4 accepted bytes.
    always @(negedge clk) begin
        if (!rst_n) begin
            pend_bytes = 0;
        end else begin
            if (bus.mem_we) begin
                we_cnt++;
                last_we_cyc = cyc;
                last_addr   = bus.mem_addr;
                check("bytes_before_write", pend_bytes, 4);
                pend_bytes = 0;
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, required no write",
                             bus.mem_addr, bus.mem_wdata);
                end else begin
                    exp_e = exp_q.pop_front();
                    check("wr_addr", bus.mem_addr, exp_e.addr);
                    check("wr_data", bus.mem_wdata, exp_e.data);
                end
            end
            if (bus.in_valid && bus.in_ready) pend_bytes++;
        end
    end

    task automatic pulse_start(input logic [10:0] len);
        @(posedge clk); #1;
        start = 1'b1;
        length_words = len;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gap);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        @(negedge clk);
        while (!bus.in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            vectors++;
            miscompares++;
            $display("FAIL byte_timeout: in_ready=0 after %0d cycles, required 1", n);
            bus.in_valid = 1'b0;
        end else begin
            @(posedge clk); #1;
            bus.in_valid = 1'b0;
            if (gap) begin
                @(posedge clk); #1;
            end
        end
    endtask

    // Returns at the first negedge with busy low; checks the WRITE->FINISH->idle latency.
    task automatic wait_idle(input bit check_latency);
        int n = 0;
        @(negedge clk);
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("idle_reached", busy, 0);
        if (check_latency) check("done_latency", cyc - last_we_cyc, 2);
    endtask

    task automatic run_load(input logic [10:0] len, input bit gap);
        wr_t e;
        for (int i = 0; i < wq.size(); i++) begin
            e.addr = 32'(i * 4);
            e.data = wq[i];
            exp_q.push_back(e);
        end
        pulse_start(len);
        for (int i = 0; i < bq.size(); i++) send_byte(bq[i], gap);
        wait_idle(1'b1);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1);
    end

    initial begin
        int base;
        rst_n        = 1'b0;
        start        = 1'b0;
        length_words = '0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;

        // Reset values.
        #1;
        check("rst_flags", {31'(0), bus.in_ready} | {26'(0), bus.mem_we, busy, done, error, cpu_rst_n, 1'b0}, 0);
        check("rst_addr", bus.mem_addr, 0);
        check("rst_wdata", bus.mem_wdata, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Basic load of two words.
        bq = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        wq = '{32'h12345678, 32'hDEADBEEF};
        base = we_cnt;
        run_load(11'd2, 1'b0);
        check("basic_we_count", we_cnt - base, 2);
        check("basic_done", done, 1);
        check("basic_cpu_rst_n", cpu_rst_n, 1);
        check("basic_error", error, 0);

        // Same image with a stalling stream.
        base = we_cnt;
        run_load(11'd2, 1'b1);
        check("stall_we_count", we_cnt - base, 2);
        check("stall_done", done, 1);

        // Length 0: done within two cycles, no writes.
        base = we_cnt;
        pulse_start(11'd0);
        @(negedge clk);
        check("len0_busy", busy, 1);
        check("len0_done_cleared", done, 0);
        @(negedge clk);
        check("len0_done", done, 1);
        check("len0_busy_low", busy, 0);
        check("len0_we_count", we_cnt - base, 0);

        // Length 1025: error, no writes, CPU stays in reset.
        base = we_cnt;
        pulse_start(11'd1025);
        @(negedge clk);
        @(negedge clk);
        check("len1025_error", error, 1);
        check("len1025_done", done, 0);
        check("len1025_cpu_rst_n", cpu_rst_n, 0);
        check("len1025_busy", busy, 0);
        check("len1025_we_count", we_cnt - base, 0);

        // Start pulse during a 3-word load is ignored.
        bq = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h11, 8'h22, 8'h33, 8'h44,
               8'hA0, 8'hB1, 8'hC2, 8'hD3};
        wq = '{32'h04030201, 32'h44332211, 32'hD3C2B1A0};
        for (int i = 0; i < 3; i++) begin
            exp_e.addr = 32'(i * 4);
            exp_e.data = wq[i];
            exp_q.push_back(exp_e);
        end
        base = we_cnt;
        pulse_start(11'd3);
        for (int i = 0; i < 6; i++) send_byte(bq[i], 1'b0);
        pulse_start(11'd5);
        for (int i = 6; i < 12; i++) send_byte(bq[i], 1'b0);
        wait_idle(1'b1);
        check("busy_start_we_count", we_cnt - base, 3);
        check("busy_start_done", done, 1);

        // Full-depth load: 1024 words, last at 0xFFC.
        bq.delete();
        wq.delete();
        for (int i = 0; i < 1024; i++) begin
            logic [7:0] b0, b1;
            b0 = 8'(i);
            b1 = 8'(i >> 8) ^ 8'h5A;
            bq.push_back(b0);
            bq.push_back(b1);
            bq.push_back(8'hC3);
            bq.push_back(~b0);
            wq.push_back({~b0, 8'hC3, b1, b0});
        end
        base = we_cnt;
        run_load(11'd1024, 1'b0);
        check("full_we_count", we_cnt - base, 1024);
        check("full_last_addr", last_addr, 32'hFFC);
        check("full_done", done, 1);

        // Reset in the middle of a 3-word load after 6 bytes.
        bq = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60};
        exp_e.addr = 32'h0;
        exp_e.data = 32'h40302010;
        exp_q.push_back(exp_e);
        base = we_cnt;
        pulse_start(11'd3);
        for (int i = 0; i < 6; i++) send_byte(bq[i], 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_cpu_rst_n", cpu_rst_n, 0);
        check("midrst_done", done, 0);
        check("midrst_in_ready", bus.in_ready, 0);
        check("midrst_we", bus.mem_we, 0);
        check("midrst_addr", bus.mem_addr, 0);
        check("midrst_wdata", bus.mem_wdata, 0);
        repeat (3) @(negedge clk);
        check("midrst_no_we", bus.mem_we, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        check("midrst_we_count", we_cnt - base, 1);
        bq = '{8'h0D, 8'hF0, 8'hFE, 8'hCA};
        wq = '{32'hCAFEF00D};
        base = we_cnt;
        run_load(11'd1, 1'b0);
        check("postrst_we_count", we_cnt - base, 1);
        check("postrst_done", done, 1);
        check("postrst_cpu_rst_n", cpu_rst_n, 1);

        // Reload: cpu_rst_n drops right after start and returns after the write.
        bq = '{8'h44, 8'h33, 8'h22, 8'h11};
        wq = '{32'h11223344};
        exp_e.addr = 32'h0;
        exp_e.data = wq[0];
        exp_q.push_back(exp_e);
        base = we_cnt;
        pulse_start(11'd1);
        check("reload_cpu_rst_low", cpu_rst_n, 0);
        check("reload_done_cleared", done, 0);
        for (int i = 0; i < 4; i++) send_byte(bq[i], 1'b0);
        wait_idle(1'b1);
        check("reload_we_count", we_cnt - base, 1);
        check("reload_cpu_rst_high", cpu_rst_n, 1);
        check("reload_done", done, 1);

        repeat (2) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
